// File: rtl/sc_cpu_pkg.sv
// Shared definitions for the single-cycle 16-bit core: datapath widths,
// reset vector and the fetch sequencer state encoding.
package sc_cpu_pkg;

    localparam int CPU_ADDR_W = 16;
    localparam int CPU_DATA_W = 16;

    localparam logic [CPU_ADDR_W-1:0] CPU_RESET_VECTOR = 16'h0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive un-acknowledged fetch cycles and pulses timeout on the
// FETCH_TIMEOUT-th one. Clear has priority over enable.
module fetch_watchdog #(
    parameter int FETCH_TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CNT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FETCH_TIMEOUT - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign timeout = en && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            // Saturate at the terminal value so the count never wraps.
            count_d = timeout ? count_q : count_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: runs the instruction-memory handshake
// and presents one instruction at a time to decode.
module pc_sequencer
    import sc_cpu_pkg::*;
#(
    parameter int                ADDR_W        = CPU_ADDR_W,
    parameter int                DATA_W        = CPU_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_VECTOR  = CPU_RESET_VECTOR,
    parameter logic [ADDR_W-1:0] INC           = ADDR_W'(1),
    parameter int                FETCH_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] inc_out,
    input  logic [ADDR_W-1:0] seq_pc,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt_req,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              halted,
    output logic              fetch_err
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic              err_q, err_d;

    logic in_fetch;
    logic wdg_timeout;

    assign in_fetch = (state_q == ST_FETCH);

    fetch_watchdog #(
        .FETCH_TIMEOUT(FETCH_TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!in_fetch || imem_ack),
        .en     (in_fetch && !imem_ack),
        .timeout(wdg_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT:  state_d = ST_FETCH;
            ST_FETCH: begin
                // A late ack on the timeout cycle still completes the fetch.
                if (imem_ack) begin
                    state_d = ST_ISSUE;
                end else if (wdg_timeout) begin
                    state_d = ST_HALT;
                end
            end
            ST_ISSUE: begin
                if (!stall) begin
                    state_d = halt_req ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        req_d    = req_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        err_d    = err_q;
        unique case (state_q)
            ST_BOOT: begin
                req_d = 1'b1;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                end else if (wdg_timeout) begin
                    req_d    = 1'b0;
                    err_d    = 1'b1;
                    halted_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                // Stall freezes everything, including redirect and halt requests.
                if (!stall) begin
                    valid_d = 1'b0;
                    if (halt_req) begin
                        halted_d = 1'b1;
                    end else begin
                        req_d = 1'b1;
                        pc_d  = branch_taken ? branch_target : seq_pc;
                    end
                end
            end
            ST_HALT: begin
                req_d    = 1'b0;
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end
            default: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_VECTOR;
            instr_q  <= '0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    assign pc_out      = pc_q;
    assign inc_out     = INC;
    assign imem_addr   = pc_q;
    assign imem_req    = req_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: an instruction-memory responder whose
// returned words are queued and compared when decode sees instr_valid.
module tb_pc_sequencer;
    import sc_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc_out, inc_out, seq_pc;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        halt_req, stall;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic        instr_valid, halted, fetch_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    // Stand-in for the downstream unsigned_adder.
    assign seq_pc = pc_out + inc_out;

    pc_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_out       (pc_out),
        .inc_out      (inc_out),
        .seq_pc       (seq_pc),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .halt_req     (halt_req),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .halted       (halted),
        .fetch_err    (fetch_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] word_at(input logic [15:0] addr);
        return addr ^ 16'hA5C3;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        halt_req      = 1'b0;
        stall         = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = 16'h0000;
    endtask

    // Leaves the DUT in BOOT, one edge away from FETCH.
    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        #2;
        check("rst_pc", pc_out, 16'h0000);
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 16'h0000);
        check("rst_halted", halted, 1'b0);
        check("rst_err", fetch_err, 1'b0);
        check("rst_inc", inc_out, 16'h0001);
        tick();
        tick();
        rst_n = 1'b1;
        check("boot_req", imem_req, 1'b0);
    endtask

    // Entered in FETCH; returns in ISSUE after `waits` wait cycles.
    task automatic run_fetch(input int waits, input logic [15:0] addr);
        check("fetch_req", imem_req, 1'b1);
        check("fetch_addr", imem_addr, addr);
        check("fetch_valid", instr_valid, 1'b0);
        for (int i = 0; i < waits; i++) begin
            imem_ack = 1'b0;
            tick();
            check("wait_req", imem_req, 1'b1);
            check("wait_err", fetch_err, 1'b0);
        end
        imem_ack   = 1'b1;
        imem_rdata = word_at(addr);
        exp_q.push_back(word_at(addr));
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
        check("issue_valid", instr_valid, 1'b1);
        check("issue_req", imem_req, 1'b0);
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            check("issue_instr", instr, exp_q.pop_front());
        end
    endtask

    // Entered in ISSUE with stall low; one edge.
    task automatic advance(input logic br, input logic [15:0] tgt);
        branch_taken  = br;
        branch_target = tgt;
        tick();
        branch_taken  = 1'b0;
        check("adv_valid", instr_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation timeout");
    end

    initial begin
        apply_reset();

        // Zero-wait sequential fetch: valid first in cycle 3, then every other.
        tick();
        check("c2_valid", instr_valid, 1'b0);
        run_fetch(0, 16'h0000);
        advance(1'b0, 16'h0000);
        run_fetch(0, 16'h0001);
        advance(1'b0, 16'h0000);
        run_fetch(0, 16'h0002);
        advance(1'b0, 16'h0000);
        run_fetch(2, 16'h0003);

        // Wrap-around of the sequential PC.
        advance(1'b1, 16'hFFFF);
        run_fetch(0, 16'hFFFF);
        advance(1'b0, 16'h0000);
        check("wrap_err", fetch_err, 1'b0);
        check("wrap_halted", halted, 1'b0);
        run_fetch(0, 16'h0000);

        // Stall in ISSUE with a pending branch.
        advance(1'b1, 16'h0005);
        run_fetch(0, 16'h0005);
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 16'h0040;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_valid", instr_valid, 1'b1);
            check("stall_pc", pc_out, 16'h0005);
            check("stall_req", imem_req, 1'b0);
            check("stall_instr", instr, word_at(16'h0005));
        end
        stall = 1'b0;
        advance(1'b1, 16'h0040);
        run_fetch(0, 16'h0040);

        // Asynchronous reset in the middle of a waiting fetch.
        advance(1'b0, 16'h0000);
        tick();
        tick();
        check("mid_req", imem_req, 1'b1);
        check("mid_addr", imem_addr, 16'h0041);
        rst_n = 1'b0;
        #1;
        check("async_req", imem_req, 1'b0);
        check("async_pc", pc_out, 16'h0000);
        check("async_valid", instr_valid, 1'b0);
        tick();
        rst_n = 1'b1;
        check("restart_boot_req", imem_req, 1'b0);
        tick();
        run_fetch(0, 16'h0000);

        // Halt beats branch; later acks are ignored.
        halt_req      = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 16'h1234;
        tick();
        clear_inputs();
        check("halt_halted", halted, 1'b1);
        check("halt_pc", pc_out, 16'h0000);
        check("halt_req", imem_req, 1'b0);
        check("halt_valid", instr_valid, 1'b0);
        imem_ack   = 1'b1;
        imem_rdata = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_hold_req", imem_req, 1'b0);
            check("halt_hold_pc", pc_out, 16'h0000);
            check("halt_hold_instr", instr, word_at(16'h0000));
            check("halt_hold_halted", halted, 1'b1);
        end
        check("halt_err", fetch_err, 1'b0);
        clear_inputs();

        // Fetch timeout: eight FETCH cycles without ack.
        apply_reset();
        tick();
        for (int i = 0; i < 7; i++) begin
            check("to_req", imem_req, 1'b1);
            check("to_err_early", fetch_err, 1'b0);
            tick();
        end
        check("to_req_last", imem_req, 1'b1);
        tick();
        check("to_err", fetch_err, 1'b1);
        check("to_halted", halted, 1'b1);
        check("to_req_drop", imem_req, 1'b0);
        check("to_pc", pc_out, 16'h0000);
        check("to_valid", instr_valid, 1'b0);

        // Ack on the eighth cycle completes normally.
        apply_reset();
        tick();
        run_fetch(7, 16'h0000);
        check("late_ack_err", fetch_err, 1'b0);
        check("late_ack_halted", halted, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter register and fetch sequencer for the single-cycle 16-bit core.
- Directly upstream of unsigned_adder: drives its val_a with the current PC and its val_b with the increment constant.
- Consumes the adder's result as the sequential next PC.
- Runs a small fetch handshake with instruction memory and presents one valid instruction at a time to decode, with stall, branch, halt and fetch-timeout handling.

Parameters:
- ADDR_W, 16, PC/address width; must equal the adder width.
- DATA_W, 16, instruction word width.
- RESET_VECTOR, 16'h0000, PC value loaded on reset.
- INC, 16'd1, constant driven onto inc_out (adder val_b).
- FETCH_TIMEOUT, 8, maximum cycles in FETCH without imem_ack before fault; must be ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_out  out  ADDR_W  current PC; to unsigned_adder val_a.
- inc_out  out  ADDR_W  constant INC; to unsigned_adder val_b.
- seq_pc  in  ADDR_W  unsigned_adder result (pc_out + inc_out, mod 2^16).
- branch_taken  in  1  redirect request, sampled only in ISSUE with stall=0.
- branch_target  in  ADDR_W  redirect address.
- halt_req  in  1  stop request, sampled only in ISSUE with stall=0.
- stall  in  1  hold the current instruction.
- imem_req  out  1  fetch request (registered).
- imem_addr  out  ADDR_W  fetch address; always equals pc_out.
- imem_ack  in  1  fetch data valid this cycle.
- imem_rdata  in  DATA_W  fetched word.
- instr  out  DATA_W  latched instruction.
- instr_valid  out  1  instr valid for decode.
- halted  out  1  core halted (sticky until reset).
- fetch_err  out  1  fetch timeout occurred (sticky until reset).

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=BOOT, pc=RESET_VECTOR.
  - imem_req=0, instr=0, instr_valid=0, halted=0, fetch_err=0, timeout count=0.
  - Reset asserted mid-fetch drops imem_req immediately and abandons the fetch.
- inc_out = INC combinationally at all times, including reset. imem_addr = pc_out.
- FSM states are BOOT, FETCH, ISSUE, HALT.
- BOOT: one cycle, then FETCH. imem_req rises on entry to FETCH.
- FETCH:
  - imem_req=1, counter increments each cycle without ack.
  - On imem_ack=1: instr<=imem_rdata, counter<=0, imem_req<=0, go to ISSUE.
  - If no ack and counter reaches FETCH_TIMEOUT-1: fetch_err<=1, halted<=1, imem_req<=0, go to HALT. PC is unchanged.
  - If ack arrives on the same cycle as the timeout, ack wins.
- ISSUE: instr_valid=1.
  - While stall=1: remain in ISSUE; pc, instr and instr_valid are held; branch_taken and halt_req are ignored.
  - When stall=0, priority is halt_req > branch_taken > sequential:
    - halt_req: pc unchanged, halted<=1, go to HALT.
    - branch_taken: pc<=branch_target, go to FETCH.
    - otherwise: pc<=seq_pc, go to FETCH.
  - instr_valid deasserts on the cycle after leaving ISSUE.
- HALT: imem_req=0, instr_valid=0, halted=1. Only reset exits this state.
- imem_ack outside FETCH is ignored (no state or PC change).
- Wrap-around: seq_pc is taken as given, so PC 16'hFFFF with INC=1 becomes 16'h0000 with no flag.
- Latency:
  - First instr_valid is 3 cycles after reset release with a zero-wait ack (BOOT, FETCH, ISSUE).
  - Steady-state throughput is 1 instruction per 2 cycles with zero-wait memory; each memory wait cycle adds 1.
- All outputs except inc_out and imem_addr come from registers.

Decomposition:
- Shared header/package sc_cpu_pkg:
  - ADDR_W and DATA_W.
  - RESET_VECTOR.
  - FSM state encodings (BOOT=2'd0, FETCH=2'd1, ISSUE=2'd2, HALT=2'd3).
- One natural sub-module: fetch_watchdog, a cycle counter with clear/enable and a timeout pulse, parameterised by FETCH_TIMEOUT.
- The PC register, FSM and instruction latch stay in pc_sequencer.
- unsigned_adder is instantiated by the parent datapath, not inside this block.

Test Plan:
- Reset then zero-wait ack with RESET_VECTOR=0 and the adder connected → imem_addr sequence 0000, 0001, 0002, with instr_valid high every other cycle, first at cycle 3.
- PC=16'hFFFF with a sequential advance → next imem_addr=16'h0000, no fault.
- In ISSUE at PC=0005, assert stall for 4 cycles with branch_taken=1, target=0040:
  - instr_valid stays high and pc stays 0005 for all 4 cycles.
  - On release with branch_taken=1, next fetch address is 0040.
- halt_req=1 and branch_taken=1 together with stall=0 → halted=1, pc unchanged, no further imem_req; a later imem_ack has no effect.
- FETCH_TIMEOUT=8 with imem_ack held low → fetch_err=1 and halted=1 after exactly 8 FETCH cycles; with ack on cycle 8 instead → normal ISSUE and fetch_err=0.
- rst_n pulsed low mid-FETCH → imem_req=0 asynchronously, pc=RESET_VECTOR, and the sequence restarts at BOOT.
